dmem_responder: RTL and testbench
=================================

# dmem_responder

Data-memory responder for the pipelined CPU's MEM stage. It answers the MemRead/MemWrite requests that the main decoder raises for LOAD and STORE instructions. Each request passes through a multi-cycle handshake, and stall_o freezes the pipeline while the access is outstanding. Storage is an internal word array. Read data returns on data_o, qualified by a one-cycle ack_o.

## Interface
- DEPTH, 256: number of 32-bit words; must be a power of two ≥ 4.
- LATENCY, 2: wait cycles in BUSY before commit; legal range 1–15.
- clk_i  in  1  clock; all state changes on rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- MemRead_i  in  1  load request from the main decoder, via the pipeline register.
- MemWrite_i  in  1  store request from the main decoder, via the pipeline register.
- addr_i  in  32  byte address (ALU result).
- data_i  in  32  store data.
- data_o  out  32  load data; holds its last value between loads.
- ack_o  out  1  one-cycle pulse on completion of any access.
- stall_o  out  1  high while a request is pending; freezes PC and all pipeline registers.
- err_o  out  1  misaligned-access flag; see Configuration.

## Operation
- The FSM has three states: IDLE, BUSY and DONE. A 4-bit down-counter cnt is used in BUSY.
- **IDLE:**
  - If MemRead_i or MemWrite_i is high, then at the edge: latch addr_i, data_i and the operation; load cnt = LATENCY; go to BUSY.
  - Otherwise stay in IDLE.
- **BUSY:**
  - Decrement cnt each edge.
  - At the edge where cnt == 1, commit the access and go to DONE.
  - A write stores the latched data at the latched word.
  - A read loads mem[word] into data_o.
- **DONE:**
  - ack_o = 1 and stall_o = 0, so the pipeline advances on this edge.
  - Request inputs are ignored in DONE.
  - Go to IDLE at the next edge.
- Word index = latched addr[log2(DEPTH)+1:2]. Higher address bits are ignored, so addresses wrap modulo DEPTH words.
- If MemRead_i and MemWrite_i are both high, the access is performed as a write only and data_o is unchanged.
- Requests must stay stable while stall_o is high. Only the values latched in IDLE are used.
- **Reset values:** state IDLE, cnt 0, data_o 0, ack_o 0, err_o 0. Memory contents are not cleared.
- **Reset asserted mid-access:** the access is aborted. An uncommitted write is never performed, and no ack_o is issued.

## Timing
- stall_o = (IDLE && (MemRead_i || MemWrite_i)) || BUSY. It is combinational in IDLE, so a request stalls its own first cycle.
- For a request first presented in cycle c:
  - stall_o is high in cycles c through c+LATENCY.
  - ack_o is high, and data_o is valid, in cycle c+LATENCY+1.
  - Total occupancy is LATENCY+2 cycles.
- The earliest next request is in cycle c+LATENCY+2, because DONE always returns to IDLE.
- data_o is registered and updates only at read commit.
- ack_o and err_o are registered and high for exactly one cycle.

## Configuration
- **With DMEM_ALIGN_CHECK_EN defined:**
  - A latched address with addr[1:0] != 0 performs no memory access and leaves data_o unchanged.
  - err_o pulses high together with ack_o in DONE.
  - Timing is identical to an aligned access.
- **Without the macro:**
  - addr[1:0] is ignored and the access proceeds on the word.
  - err_o is tied to 0.

## Test plan
- Reset with DEPTH=256, LATENCY=2 → data_o=0, ack_o=0, stall_o=0, err_o=0. Assert rst_i mid-BUSY → FSM returns to IDLE immediately.
- Write 0xDEADBEEF to 0x10, then read 0x10 → stall_o high 3 cycles per access; ack_o in the 4th cycle; data_o=0xDEADBEEF.
- Write 0x12345678 to 0x400, then read 0x000 → data_o=0x12345678 (wrap at 256 words).
- Start a write of 0xA5A5A5A5 to 0x20 over old 0x11111111, assert rst_i in the first BUSY cycle, then read 0x20 → data_o=0x11111111, and no ack_o occurs during the aborted access.
- MemRead_i=MemWrite_i=1 to 0x8 with data 0x55 → the word becomes 0x55 and data_o keeps its prior value; a follow-up read returns 0x55.
- With DMEM_ALIGN_CHECK_EN defined, read 0x13 → err_o=1 with ack_o and data_o unchanged. Without the macro → data_o = mem[4], err_o=0.

Source files
------------

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder for the MEM stage: IDLE/BUSY/DONE handshake over an internal word array.
// Optional misaligned-access detection is enabled by defining DMEM_ALIGN_CHECK_EN.
module dmem_responder #(
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        MemRead_i,
    input  logic        MemWrite_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] data_i,
    output logic [31:0] data_o,
    output logic        ack_o,
    output logic        stall_o,
    output logic        err_o
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_q;
    logic [3:0]      cnt_q;
    logic [AW-1:0]   word_q;
    logic [AW-1:0]   word_d;
    logic [31:0]     wdata_q;
    logic [31:0]     data_q;
    logic            is_write_q;
    logic            ack_q;
    logic            req;
    logic            commit;
    logic            access_ok;
    logic [31:0]     mem_q [DEPTH];

    assign req    = MemRead_i | MemWrite_i;
    assign word_d = addr_i[AW+1:2];
    assign commit = (state_q == BUSY) && (cnt_q == 4'd1);

`ifdef DMEM_ALIGN_CHECK_EN
    logic misal_q;
    logic misal_d;
    logic err_q;
    logic unused_addr_bits;
    assign misal_d          = (addr_i[1:0] != 2'b00);
    assign access_ok        = ~misal_q;
    assign err_o            = err_q;
    assign unused_addr_bits = ^addr_i[31:AW+2];
`else
    logic unused_addr_bits;
    assign access_ok        = 1'b1;
    assign err_o            = 1'b0;
    assign unused_addr_bits = ^{addr_i[31:AW+2], addr_i[1:0]};
`endif

    // A request stalls its own first cycle, hence the combinational IDLE term.
    assign stall_o = ((state_q == IDLE) && req) || (state_q == BUSY);
    assign ack_o   = ack_q;
    assign data_o  = data_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            cnt_q      <= 4'd0;
            word_q     <= '0;
            wdata_q    <= 32'd0;
            is_write_q <= 1'b0;
            data_q     <= 32'd0;
            ack_q      <= 1'b0;
`ifdef DMEM_ALIGN_CHECK_EN
            misal_q    <= 1'b0;
            err_q      <= 1'b0;
`endif
        end else begin
            ack_q <= 1'b0;
`ifdef DMEM_ALIGN_CHECK_EN
            err_q <= 1'b0;
`endif
            case (state_q)
                IDLE: begin
                    if (req) begin
                        word_q     <= word_d;
                        wdata_q    <= data_i;
                        is_write_q <= MemWrite_i;
`ifdef DMEM_ALIGN_CHECK_EN
                        misal_q    <= misal_d;
`endif
                        cnt_q      <= 4'(LATENCY);
                        state_q    <= BUSY;
                    end
                end
                BUSY: begin
                    cnt_q <= cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        state_q <= DONE;
                        ack_q   <= 1'b1;
                        // Read-and-write together counts as a write, so data_o is left alone.
                        if (!is_write_q && access_ok) begin
                            data_q <= mem_q[word_q];
                        end
`ifdef DMEM_ALIGN_CHECK_EN
                        err_q <= misal_q;
`endif
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Storage is not reset; gating on rst_i keeps an aborted write from landing.
    always_ff @(posedge clk_i) begin
        if (commit && is_write_q && access_ok && !rst_i) begin
            mem_q[word_q] <= wdata_q;
        end
    end
endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed vector table, reset-abort sequence and randomized accesses.
module tb_dmem_responder;
    localparam int LAT   = 2;
    localparam int DEPTH = 256;

    logic        clk;
    logic        rst;
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] data_o;
    logic        ack;
    logic        stall;
    logic        err;

    int errors = 0;
    int checks = 0;

    logic [31:0] mmem   [DEPTH];
    bit          mvalid [DEPTH];
    logic [31:0] mdata;

    typedef struct {
        bit          r;
        bit          w;
        logic [31:0] a;
        logic [31:0] d;
        logic [31:0] ed;
        bit          ee;
    } vec_t;

    vec_t tbl [9];

    dmem_responder #(.DEPTH(DEPTH), .LATENCY(LAT)) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .MemRead_i (rd),
        .MemWrite_i(wr),
        .addr_i    (addr),
        .data_i    (wdata),
        .data_o    (data_o),
        .ack_o     (ack),
        .stall_o   (stall),
        .err_o     (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s %s: got %h expected %h", tag, name, act, exp);
        end
    endtask

    function automatic bit is_misal(input logic [31:0] a);
`ifdef DMEM_ALIGN_CHECK_EN
        return (a[1:0] != 2'b00);
`else
        return 1'b0;
`endif
    endfunction

    // Reference: a word array indexed by byte address / 4 modulo DEPTH.
    task automatic model(input bit r, input bit w, input logic [31:0] a, input logic [31:0] d,
                         output logic [31:0] ed, output bit ee);
        int idx;
        idx = int'(a[31:2]) % DEPTH;
        ee  = is_misal(a);
        if (!ee) begin
            if (w) begin
                mmem[idx]   = d;
                mvalid[idx] = 1'b1;
            end else if (r) begin
                mdata = mmem[idx];
            end
        end
        ed = mdata;
    endtask

    task automatic run_access(input string tag, input bit r, input bit w, input logic [31:0] a,
                              input logic [31:0] d, input logic [31:0] ed, input bit ee);
        @(negedge clk);
        rd = r; wr = w; addr = a; wdata = d;
        #1;
        chk(tag, "stall_c0", stall, 1);
        chk(tag, "ack_c0", ack, 0);
        for (int k = 1; k <= LAT; k++) begin
            @(negedge clk);
            chk(tag, "stall_busy", stall, 1);
            chk(tag, "ack_busy", ack, 0);
        end
        @(negedge clk);
        chk(tag, "stall_done", stall, 0);
        chk(tag, "ack_done", ack, 1);
        chk(tag, "data_done", data_o, ed);
        chk(tag, "err_done", err, ee);
        rd = 1'b0; wr = 1'b0;
        @(negedge clk);
        chk(tag, "ack_after", ack, 0);
        chk(tag, "stall_after", stall, 0);
        chk(tag, "err_after", err, 0);
        chk(tag, "data_hold", data_o, ed);
        $display("txn %s r=%0d w=%0d addr=%h wdata=%h data_o=%h err=%0b", tag, r, w, a, d, data_o, err);
    endtask

    initial begin
        logic [31:0] ed;
        bit          ee;
        bit          r;
        bit          w;
        logic [31:0] a;
        logic [31:0] d;
        int          op;

        rst = 1'b1; rd = 1'b0; wr = 1'b0; addr = 32'd0; wdata = 32'd0;
        mdata = 32'd0;
        for (int i = 0; i < DEPTH; i++) begin
            mvalid[i] = 1'b0;
            mmem[i]   = 32'd0;
        end
        repeat (2) @(negedge clk);
        chk("reset", "data_o", data_o, 0);
        chk("reset", "ack", ack, 0);
        chk("reset", "stall", stall, 0);
        chk("reset", "err", err, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_reset", "stall", stall, 0);
        chk("post_reset", "ack", ack, 0);

        tbl[0] = '{1'b0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0};
        tbl[1] = '{1'b1, 1'b0, 32'h0000_0010, 32'h0000_0000, 32'hDEAD_BEEF, 1'b0};
        tbl[2] = '{1'b0, 1'b1, 32'h0000_0400, 32'h1234_5678, 32'hDEAD_BEEF, 1'b0};
        tbl[3] = '{1'b1, 1'b0, 32'h0000_0000, 32'h0000_0000, 32'h1234_5678, 1'b0};
        tbl[4] = '{1'b0, 1'b1, 32'h0000_0020, 32'h1111_1111, 32'h1234_5678, 1'b0};
        tbl[5] = '{1'b1, 1'b1, 32'h0000_0008, 32'h0000_0055, 32'h1234_5678, 1'b0};
        tbl[6] = '{1'b1, 1'b0, 32'h0000_0008, 32'h0000_0000, 32'h0000_0055, 1'b0};
        tbl[7] = '{1'b0, 1'b1, 32'h0000_0010, 32'hCAFE_F00D, 32'h0000_0055, 1'b0};
`ifdef DMEM_ALIGN_CHECK_EN
        tbl[8] = '{1'b1, 1'b0, 32'h0000_0013, 32'h0000_0000, 32'h0000_0055, 1'b1};
`else
        tbl[8] = '{1'b1, 1'b0, 32'h0000_0013, 32'h0000_0000, 32'hCAFE_F00D, 1'b0};
`endif

        for (int i = 0; i < 9; i++) begin
            run_access($sformatf("vec%0d", i), tbl[i].r, tbl[i].w, tbl[i].a, tbl[i].d, tbl[i].ed, tbl[i].ee);
            model(tbl[i].r, tbl[i].w, tbl[i].a, tbl[i].d, ed, ee);
        end

        // Abort a write in its first BUSY cycle; the old word must survive and no ack may appear.
        @(negedge clk);
        rd = 1'b0; wr = 1'b1; addr = 32'h20; wdata = 32'hA5A5_A5A5;
        #1;
        chk("abort", "stall_c0", stall, 1);
        @(negedge clk);
        chk("abort", "stall_busy", stall, 1);
        chk("abort", "ack_busy", ack, 0);
        rst = 1'b1; wr = 1'b0;
        #1;
        chk("abort", "stall_rst", stall, 0);
        chk("abort", "ack_rst", ack, 0);
        chk("abort", "data_rst", data_o, 0);
        @(negedge clk);
        chk("abort", "ack_rst2", ack, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("abort", "stall_rel", stall, 0);
        @(negedge clk);
        chk("abort", "ack_rel", ack, 0);
        mdata = 32'd0;
        run_access("abort_rd", 1'b1, 1'b0, 32'h20, 32'h0, 32'h1111_1111, 1'b0);
        model(1'b1, 1'b0, 32'h20, 32'h0, ed, ee);

        for (int n = 0; n < 150; n++) begin
            op = int'($urandom_range(0, 2));
            r  = (op != 0);
            w  = (op != 1);
            a  = $urandom;
            d  = $urandom;
            if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
            if (r && !w && !is_misal(a) && !mvalid[int'(a[31:2]) % DEPTH]) w = 1'b1;
            model(r, w, a, d, ed, ee);
            run_access($sformatf("rnd%0d", n), r, w, a, d, ed, ee);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
